spi_frame_master: RTL and testbench

- Board-to-board SPI master that drives one 32-bit frame per rising edge of the simulation clock (sim_clk).
- Sends a 32-bit word on MOSI, for example f_muscle_len on board 1.
- Captures the 32-bit reply on MISO, for example f_rawfr_Ia returned by the spindle board's slave.
- It is the initiating end of the existing jp1/jp2 SPI link (SCK/MOSI/MISO/SSEL) and replaces the ad-hoc master on the sending board.

---
 rtl/spi_link_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 26 ++
 rtl/spi_frame_master.sv | 142 ++++++++++++++
 tb/tb_spi_frame_master.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// Shared definitions for both ends of the board-to-board SPI link.
package spi_link_pkg;

   localparam int unsigned SPI_DATA_W = 32;
   localparam int unsigned SPI_DIV_W  = 24;

   // SCK half-period minus one used when nothing else is configured.
   localparam logic [SPI_DIV_W-1:0] SPI_CLKDIV_DEFAULT = SPI_DIV_W'(13);

   typedef enum logic [2:0] {
      StIdle,
      StLead,
      StShift,
      StTrail,
      StGap
   } spi_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector producing a one-cycle pulse in the clk domain.
module sync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   logic [2:0] sync;
   logic       prev;

   // Shift the async level through the synchronizer and keep its last value.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[1:0], async_in};
         prev <= sync[2];
      end
   end

   assign pulse = sync[2] & ~prev;

endmodule

// File: rtl/spi_frame_master.sv
// Mode-0 SPI master that sends and receives one frame per rising edge of an
// asynchronous trigger (sim_clk). MSB first, SCK half-period = clkdiv+1 clks.
module spi_frame_master
   import spi_link_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DATA_W,
   parameter int unsigned DIV_W  = SPI_DIV_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DIV_W-1:0]  clkdiv,
   input  logic              sim_clk,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              MISO,
   output logic              SCK,
   output logic              MOSI,
   output logic              SSEL,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              overrun
);

   localparam int unsigned BitW = $clog2(DATA_W + 1);

   logic              start;
   spi_state_t        state;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  cnt;
   logic [BitW-1:0]   bit_cnt;
   // Bits still to be sent after the one currently on MOSI.
   logic [DATA_W-2:0] tx_rem;
   logic [DATA_W-1:0] rx_shift;
   logic              cnt_done;

   sync_edge_detect u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (sim_clk),
      .pulse    (start)
   );

   // Half-period elapses on the cycle the counter hits the divider latched at start.
   assign cnt_done = (cnt == div_q);

   // Frame sequencer; all link outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= StIdle;
         div_q    <= '0;
         cnt      <= '0;
         bit_cnt  <= '0;
         tx_rem   <= '0;
         rx_shift <= '0;
         SCK      <= 1'b0;
         MOSI     <= 1'b0;
         SSEL     <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         // Any trigger outside IDLE is dropped, including the GAP->IDLE cycle.
         if (start && (state != StIdle)) begin
            overrun <= 1'b1;
         end
         case (state)
            StIdle: begin
               if (start && en) begin
                  tx_rem  <= tx_data[DATA_W-2:0];
                  MOSI    <= tx_data[DATA_W-1];
                  SSEL    <= 1'b0;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  cnt     <= '0;
                  div_q   <= clkdiv;
                  state   <= StLead;
               end
            end
            StLead: begin
               if (cnt_done) begin
                  // First rise: the slave has had H cycles to present bit 0.
                  cnt      <= '0;
                  SCK      <= 1'b1;
                  rx_shift <= {rx_shift[DATA_W-2:0], MISO};
                  bit_cnt  <= bit_cnt + 1'b1;
                  state    <= StShift;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StShift: begin
               if (cnt_done) begin
                  cnt <= '0;
                  if (!SCK) begin
                     SCK      <= 1'b1;
                     rx_shift <= {rx_shift[DATA_W-2:0], MISO};
                     bit_cnt  <= bit_cnt + 1'b1;
                  end else begin
                     SCK <= 1'b0;
                     if (bit_cnt == BitW'(DATA_W)) begin
                        state <= StTrail;
                     end else begin
                        MOSI   <= tx_rem[DATA_W-2];
                        tx_rem <= {tx_rem[DATA_W-3:0], 1'b0};
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StTrail: begin
               if (cnt_done) begin
                  cnt      <= '0;
                  SSEL     <= 1'b1;
                  MOSI     <= 1'b0;
                  rx_data  <= rx_shift;
                  rx_valid <= 1'b1;
                  state    <= StGap;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StGap: begin
               if (cnt_done) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: mode-0 slave model plus a frame-level
// reference (expected words, 65H SSEL-low, 66H busy, 32 SCK rises, one rx_valid).
module tb_spi_frame_master;
   import spi_link_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b1;
   logic [23:0] clkdiv = 24'd13;
   logic        sim_clk = 1'b0;
   logic [31:0] tx_data = '0;
   logic        MISO;
   logic        SCK;
   logic        MOSI;
   logic        SSEL;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        busy;
   logic        overrun;

   always #5 clk = ~clk;

   spi_frame_master dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clkdiv   (clkdiv),
      .sim_clk  (sim_clk),
      .tx_data  (tx_data),
      .MISO     (MISO),
      .SCK      (SCK),
      .MOSI     (MOSI),
      .SSEL     (SSEL),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .overrun  (overrun)
   );

   // Mode-0 slave: first bit out on SSEL fall, next bit on each SCK fall,
   // MOSI captured on each SCK rise.
   logic [31:0] slave_reply = '0;
   logic [31:0] slave_tx = '0;
   logic [31:0] slave_rx = '0;
   logic        miso_drv = 1'b0;
   bit          miso_tie = 1'b0;
   int          sck_rises = 0;
   int          ssel_falls = 0;

   assign MISO = miso_tie ? 1'b1 : miso_drv;

   always @(negedge SSEL) begin
      ssel_falls++;
      slave_tx = slave_reply;
      miso_drv = slave_tx[31];
   end

   always @(posedge SCK) begin
      sck_rises++;
      slave_rx = {slave_rx[30:0], MOSI};
   end

   always @(negedge SCK) begin
      if (SSEL === 1'b0) begin
         slave_tx = slave_tx << 1;
         miso_drv = slave_tx[31];
      end
   end

   // Running cycle counts, sampled mid-cycle.
   int low_tot = 0;
   int busy_tot = 0;
   int valid_tot = 0;

   always @(negedge clk) begin
      if (SSEL === 1'b0) low_tot++;
      if (busy === 1'b1) busy_tot++;
      if (rx_valid === 1'b1) valid_tot++;
   end

   int n_checks = 0;
   int n_fail = 0;
   bit exp_overrun = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // One full frame against the reference; mid_div/drop_en are applied once the
   // frame is running, second_at (>0) re-triggers that many cycles after the first rise.
   task automatic do_frame(input logic [23:0] div, input logic [31:0] tx, input logic [31:0] rep,
                           input bit tie1, input bit drop_en, input logic [23:0] mid_div,
                           input int second_at, input string name);
      int          lat;
      int          n;
      int          h;
      int          low0, busy0, val0, rise0, fall0;
      logic [31:0] exp_rx;
      h      = int'(div) + 1;
      exp_rx = tie1 ? 32'hFFFF_FFFF : rep;
      clkdiv = div;
      tx_data = tx;
      slave_reply = rep;
      miso_tie = tie1;
      low0  = low_tot;
      busy0 = busy_tot;
      val0  = valid_tot;
      rise0 = sck_rises;
      fall0 = ssel_falls;
      sim_clk = 1'b1;
      lat = 0;
      while (busy !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check({name, ".started"}, busy, 1'b1);
      check({name, ".trig_latency_ok"}, (lat >= 4 && lat <= 5), 1'b1);
      // Inputs after start must not affect this frame.
      tx_data = ~tx;
      clkdiv  = mid_div;
      if (drop_en) en = 1'b0;
      sim_clk = 1'b0;
      if (second_at > 0) begin
         repeat (second_at - lat) step();
         sim_clk = 1'b1;
         repeat (5) step();
         sim_clk = 1'b0;
         exp_overrun = 1'b1;
      end
      n = 0;
      while (busy === 1'b1 && n < 70 * h + 20) begin
         step();
         n++;
      end
      check({name, ".finished"}, busy, 1'b0);
      check({name, ".busy_cycles"}, busy_tot - busy0, 66 * h);
      check({name, ".ssel_low_cycles"}, low_tot - low0, 65 * h);
      check({name, ".rx_valid_pulses"}, valid_tot - val0, 1);
      check({name, ".sck_rises"}, sck_rises - rise0, 32);
      check({name, ".frames"}, ssel_falls - fall0, 1);
      check({name, ".slave_rx"}, slave_rx, tx);
      check({name, ".rx_data"}, rx_data, exp_rx);
      check({name, ".overrun"}, overrun, exp_overrun);
      check({name, ".idle_lines"}, {SCK, SSEL, MOSI}, 3'b010);
      en = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      int          n;
      int          r0;
      int          f0;
      logic [23:0] d;
      logic [31:0] a;
      logic [31:0] b;

      repeat (3) step();
      check("rst.SCK", SCK, 1'b0);
      check("rst.MOSI", MOSI, 1'b0);
      check("rst.SSEL", SSEL, 1'b1);
      check("rst.rx_data", rx_data, 32'h0);
      check("rst.rx_valid", rx_valid, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.overrun", overrun, 1'b0);
      reset = 1'b0;
      repeat (4) step();

      // Loopback and fastest divider.
      do_frame(24'd13, 32'h3F80_0000, 32'hA5A5_0F0F, 1'b0, 1'b0, 24'd13, 0, "loopback");
      do_frame(24'd0, 32'hFFFF_0001, 32'h0, 1'b1, 1'b0, 24'd0, 0, "fastdiv");

      // Overrun: second trigger 200 cycles into a frame; flag stays sticky.
      do_frame(24'd13, $urandom, $urandom, 1'b0, 1'b0, 24'd13, 200, "overrun");
      do_frame(24'd2, $urandom, $urandom, 1'b0, 1'b0, 24'd2, 0, "overrun_sticky");

      // Reset during bit 10.
      clkdiv = 24'd13;
      slave_reply = $urandom;
      tx_data = $urandom;
      sim_clk = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      sim_clk = 1'b0;
      r0 = sck_rises;
      n = 0;
      while (sck_rises - r0 < 10 && n < 2000) begin
         step();
         n++;
      end
      check("midrst.reached_bit10", sck_rises - r0, 10);
      reset = 1'b1;
      step();
      check("midrst.SSEL", SSEL, 1'b1);
      check("midrst.SCK", SCK, 1'b0);
      check("midrst.MOSI", MOSI, 1'b0);
      check("midrst.rx_data", rx_data, 32'h0);
      check("midrst.busy", busy, 1'b0);
      check("midrst.overrun", overrun, 1'b0);
      reset = 1'b0;
      exp_overrun = 1'b0;
      repeat (4) step();
      do_frame(24'd5, $urandom, $urandom, 1'b0, 1'b0, 24'd5, 0, "after_rst");

      // en low at trigger: nothing happens.
      f0 = ssel_falls;
      en = 1'b0;
      sim_clk = 1'b1;
      repeat (6) step();
      sim_clk = 1'b0;
      repeat (20) step();
      check("en_off.frames", ssel_falls - f0, 0);
      check("en_off.busy", busy, 1'b0);
      check("en_off.overrun", overrun, 1'b0);
      en = 1'b1;
      repeat (2) step();
      do_frame(24'd4, $urandom, $urandom, 1'b0, 1'b1, 24'd4, 0, "en_drop");

      // Divider change mid-frame only affects the following frame.
      do_frame(24'd13, $urandom, $urandom, 1'b0, 1'b0, 24'd3, 0, "div_keep");
      do_frame(24'd3, $urandom, $urandom, 1'b0, 1'b0, 24'd3, 0, "div_new");

      // Randomized frames.
      for (int i = 0; i < 6; i++) begin
         d = 24'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         do_frame(d, a, b, 1'b0, 1'b0, 24'($urandom_range(0, 15)), 0, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
